// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int CNT_W_DEF = 8;

  typedef logic [CNT_W_DEF-1:0] div_t;

  // A half-period of zero cycles has no meaning; such writes are dropped.
  function automatic logic div_valid(input div_t d);
    return (d != '0);
  endfunction

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: half-period counter, live divisor, pending divisor,
// registered square wave and rising-edge strobe.
module tick_div_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst,      // synchronous, active low
  input  logic             en,
  input  logic             sync,
  input  logic             we,       // already qualified: nonzero and addressed here
  input  logic [CNT_W-1:0] wdata,
  output logic             clk_out,
  output logic             tick_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pend;
  logic             pend_vld;
  logic             clk_q;
  logic             tick_q;
  logic             terminal;

  // Last cycle of the current half-period; div_reg is never 0 so the
  // subtraction cannot underflow.
  always_comb begin
    terminal = (cnt == (div_reg - CNT_W'(1)));
  end

  // Priority: reset, disable, sync, terminal count, count. A new divisor only
  // takes effect where the counter restarts, so no half-period is truncated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      div_reg  <= DIV_RST;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      if (pend_vld) div_reg <= pend;
      pend_vld <= we;
      if (we) pend <= wdata;
    end else if (sync) begin
      // Same-cycle write wins over an older pending value.
      cnt      <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_vld <= 1'b0;
      if (we)            div_reg <= wdata;
      else if (pend_vld) div_reg <= pend;
    end else if (terminal) begin
      // A write landing on the terminal cycle waits for the next one.
      cnt    <= '0;
      clk_q  <= ~clk_q;
      tick_q <= ~clk_q;
      if (pend_vld) div_reg <= pend;
      pend_vld <= we;
      if (we) pend <= wdata;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      tick_q <= 1'b0;
      if (we) begin
        pend     <= wdata;
        pend_vld <= 1'b1;
      end
    end
  end

  assign clk_out  = clk_q;
  assign tick_out = tick_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable clock/tick generator on the 1 MHz system clock.
// Decodes divisor writes to a channel and fans sync out to all channels.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd50, 8'd5},
  localparam int                     CH_W     = $clog2(NUM_CH)
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_out
);

  logic              div_ok;
  logic              ch_ok;
  logic              wr_ok;
  logic [NUM_CH-1:0] we_vec;

  // Zero-divisor check through the shared helper when widths line up.
  if (CNT_W == CNT_W_DEF) begin : g_div_chk
    assign div_ok = div_valid(cfg_div);
  end else begin : g_div_chk_w
    assign div_ok = |cfg_div;
  end

  // Channel indices past the last channel are dropped (non power-of-two NUM_CH).
  assign ch_ok = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  assign wr_ok = cfg_we & div_ok & ch_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we_vec[i] = wr_ok & (cfg_ch == CH_W'(i));

    tick_div_channel #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk      (clock_1MHz),
      .rst      (rst),
      .en       (ch_enable[i]),
      .sync     (sync_in),
      .we       (we_vec[i]),
      .wdata    (cfg_div),
      .clk_out  (clk_out[i]),
      .tick_out (tick_out[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: table-driven start-up vectors, directed
// corner sequences, and randomized traffic against a timestamp-based model.
module tb_tick_gen;

  logic       clock_1MHz = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] ch_enable = '0;
  logic       cfg_we = 1'b0;
  logic       cfg_ch = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       sync_in = 1'b0;
  logic [1:0] clk_out, tick_out;

  // three-channel instance for index decode
  logic [2:0] en3 = '0;
  logic       cfg_we3 = 1'b0;
  logic [1:0] cfg_ch3 = '0;
  logic [7:0] cfg_div3 = '0;
  logic       sync3 = 1'b0;
  logic [2:0] clk3, tick3;

  int n_chk = 0;
  int n_fail = 0;

  tick_gen dut (
    .clock_1MHz (clock_1MHz), .rst (rst), .ch_enable (ch_enable),
    .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
    .sync_in (sync_in), .clk_out (clk_out), .tick_out (tick_out)
  );

  tick_gen #(.NUM_CH(3), .CNT_W(8), .DIV_INIT({8'd3, 8'd4, 8'd2})) dut3 (
    .clock_1MHz (clock_1MHz), .rst (rst), .ch_enable (en3),
    .cfg_we (cfg_we3), .cfg_ch (cfg_ch3), .cfg_div (cfg_div3),
    .sync_in (sync3), .clk_out (clk3), .tick_out (tick3)
  );

  always #5 clock_1MHz = ~clock_1MHz;

  // ---------------- reference model ----------------
  // Each half-period is a window of div enabled edges starting at m_hp;
  // the edge that closes the window flips the level.
  int         t = 0;
  int         m_div[2] = '{5, 50};
  int         m_pend[2] = '{0, 0};    // 0 = nothing pending
  int         m_hp[2] = '{1, 1};
  logic [1:0] m_clk = '0;
  logic [1:0] m_tick = '0;
  bit         m_wr;
  int         m_init[2] = '{5, 50};

  always @(posedge clock_1MHz) begin
    t++;
    for (int c = 0; c < 2; c++) begin
      m_wr = cfg_we && (cfg_div != 0) && (int'(cfg_ch) == c);
      if (!rst) begin
        m_clk[c] = 0; m_tick[c] = 0; m_div[c] = m_init[c]; m_pend[c] = 0; m_hp[c] = t + 1;
      end else if (!ch_enable[c]) begin
        m_clk[c] = 0; m_tick[c] = 0;
        if (m_pend[c] != 0) m_div[c] = m_pend[c];
        m_pend[c] = m_wr ? int'(cfg_div) : 0;
        m_hp[c] = t + 1;
      end else if (sync_in) begin
        m_clk[c] = 0; m_tick[c] = 0;
        if (m_wr) m_div[c] = int'(cfg_div);
        else if (m_pend[c] != 0) m_div[c] = m_pend[c];
        m_pend[c] = 0;
        m_hp[c] = t + 1;
      end else if (t - m_hp[c] + 1 == m_div[c]) begin
        m_clk[c] = ~m_clk[c];
        m_tick[c] = m_clk[c];
        if (m_pend[c] != 0) m_div[c] = m_pend[c];
        m_pend[c] = m_wr ? int'(cfg_div) : 0;
        m_hp[c] = t + 1;
      end else begin
        m_tick[c] = 0;
        if (m_wr) m_pend[c] = int'(cfg_div);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock edge; one-cycle pulses are dropped after it
  task automatic tick_c();
    @(posedge clock_1MHz);
    #1;
    cfg_we = 1'b0; sync_in = 1'b0;
    cfg_we3 = 1'b0; sync3 = 1'b0;
  endtask

  // next tick on channel ch must land exactly on the n-th edge from now
  task automatic run_check(input int ch, input int n, input string name);
    int first = 0;
    for (int i = 1; i <= n; i++) begin
      tick_c();
      if (tick_out[ch] && first == 0) first = i;
    end
    check(name, first, n);
  endtask

  task automatic count3(input int edges, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < edges; i++) begin
      tick_c();
      c0 += int'(tick3[0]); c1 += int'(tick3[1]); c2 += int'(tick3[2]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; ch_enable = '0; en3 = '0;
    tick_c(); tick_c();
    check("reset clk_out", clk_out, 2'b00);
    check("reset tick_out", tick_out, 2'b00);
    check("reset clk3", clk3, 3'b000);
    rst = 1'b1;
  endtask

  typedef struct {
    int         cyc;       // edges since enable
    logic [1:0] en;
    logic [1:0] exp_clk;
    logic [1:0] exp_tick;
  } vec_t;

  vec_t vecs[11];
  int   k;
  int   c0, c1, c2;

  initial begin
    // start-up timing with default divisors 5 and 50
    vecs[0]  = '{1,   2'b11, 2'b00, 2'b00};
    vecs[1]  = '{4,   2'b11, 2'b00, 2'b00};
    vecs[2]  = '{5,   2'b11, 2'b01, 2'b01};
    vecs[3]  = '{6,   2'b11, 2'b01, 2'b00};
    vecs[4]  = '{10,  2'b11, 2'b00, 2'b00};
    vecs[5]  = '{15,  2'b11, 2'b01, 2'b01};
    vecs[6]  = '{25,  2'b11, 2'b01, 2'b01};
    vecs[7]  = '{50,  2'b11, 2'b10, 2'b10};
    vecs[8]  = '{55,  2'b11, 2'b11, 2'b01};
    vecs[9]  = '{100, 2'b11, 2'b00, 2'b00};
    vecs[10] = '{150, 2'b11, 2'b10, 2'b10};

    do_reset();
    k = 0;
    foreach (vecs[v]) begin
      while (k < vecs[v].cyc) begin
        ch_enable = vecs[v].en;
        tick_c();
        k++;
      end
      check($sformatf("vec%0d clk", v), clk_out, vecs[v].exp_clk);
      check($sformatf("vec%0d tick", v), tick_out, vecs[v].exp_tick);
    end

    // reprogram ch0 to 3 when its counter is 1: current half-period still 5
    tick_c();
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd3;
    run_check(0, 4, "s2 old half-period");
    run_check(0, 6, "s2 new period a");
    run_check(0, 6, "s2 new period b");

    // zero divisor is ignored
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd0;
    run_check(0, 6, "s3 div0 ignored");

    // sync mid-period
    do_reset();
    ch_enable = 2'b11;
    for (int i = 0; i < 17; i++) tick_c();
    check("s4 pre-sync ch0 high", clk_out[0], 1'b1);
    sync_in = 1'b1;
    tick_c();
    check("s4 sync clears clk", clk_out, 2'b00);
    run_check(0, 5, "s4 ch0 after sync");
    run_check(1, 45, "s4 ch1 after sync");

    // drop ch1 mid-period, then re-enable
    ch_enable = 2'b01;
    tick_c();
    check("s5 ch1 off", clk_out[1], 1'b0);
    run_check(0, 4, "s5 ch0 unaffected");
    for (int i = 0; i < 7; i++) tick_c();
    ch_enable = 2'b11;
    run_check(1, 50, "s5 ch1 re-enable");

    // reset with a pending write while clk_out[1] is high
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd2;
    tick_c();
    check("s6 pre-reset ch1 high", clk_out[1], 1'b1);
    rst = 1'b0;
    tick_c();
    check("s6 reset clk", clk_out, 2'b00);
    check("s6 reset tick", tick_out, 2'b00);
    rst = 1'b1;
    run_check(0, 5, "s6 ch0 restart");
    run_check(1, 45, "s6 ch1 restart");
    run_check(1, 100, "s6 ch1 pending dropped");

    // 3-channel instance: an out-of-range index must not disturb anything
    do_reset();
    en3 = 3'b111;
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd1;
    count3(24, c0, c1, c2);
    check("n3 ch0 ticks", c0, 6);
    check("n3 ch1 ticks", c1, 3);
    check("n3 ch2 ticks", c2, 4);
    cfg_we3 = 1'b1; cfg_ch3 = 2'd2; cfg_div3 = 8'd1;
    count3(24, c0, c1, c2);
    check("n3 ch0 ticks b", c0, 6);
    check("n3 ch1 ticks b", c1, 3);
    check("n3 ch2 div1 ticks", c2, 11);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      ch_enable = {($urandom_range(0, 19) != 0), ($urandom_range(0, 19) != 0)};
      sync_in   = ($urandom_range(0, 39) == 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_ch    = 1'($urandom_range(0, 1));
      cfg_div   = 8'($urandom_range(0, 6));
      tick_c();
      check($sformatf("rand cyc %0d", i), {clk_out, tick_out}, {m_clk, m_tick});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end

endmodule
